// File: rtl/delay_line_ram.sv
// delay_line_ram
//   Multi-channel circular sample buffer on one inferred block RAM. Each
//   accepted sample is written into its channel's ring. The sample from
//   `delay` frames earlier on the same channel comes out one cycle later.
//   After every reset the whole RAM is written with zeros before any input
//   is accepted, so stale audio never reaches the output.
// Ports
//   clk, rst         clock, synchronous active-high reset
//   i_valid/i_ready  input handshake (i_ready is low while clearing)
//   i_channel        channel of i_sample
//   i_sample         input sample, W bits
//   delay            delay in frames, sampled on accept
//   o_valid          one-cycle strobe for o_channel/o_sample
//   o_channel        channel of o_sample
//   o_sample         delayed sample
module delay_line_ram #(
  parameter  int W        = 16,
  parameter  int CHANNELS = 2,
  parameter  int DEPTH    = 1024,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int FW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [CW-1:0] i_channel,
  input  logic [W-1:0]  i_sample,
  input  logic [FW-1:0] delay,
  output logic          o_valid,
  output logic [CW-1:0] o_channel,
  output logic [W-1:0]  o_sample
);

  localparam int N  = CHANNELS * DEPTH;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW:0] CH_LIM = (CW+1)'(CHANNELS);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_clr_addr;
  logic [FW-1:0] r_wr_ptr;
  logic          r_ready;

  logic [W-1:0]  r_mem [0:N-1];
  logic [W-1:0]  r_rdata;

  logic          r_ovalid;
  logic [CW-1:0] r_och;
  logic          r_sel_byp;
  logic [W-1:0]  r_byp;

  logic          w_ch_ok, w_ch_last, w_do, w_bypass, w_re, w_we, w_clear;
  logic [FW-1:0] w_rd_idx;
  logic [AW-1:0] w_base, w_waddr, w_raddr;
  logic [W-1:0]  w_wdata;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_RUN);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_addr == AW'(N-1)) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                   r_clr_addr <= '0;
    else if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
  end

  // ---------------- datapath ----------------
  assign w_clear   = (r_state == S_CLEAR);
  assign w_ch_ok   = ({1'b0, i_channel} < CH_LIM);
  assign w_ch_last = (i_channel == CW'(CHANNELS-1));
  // Out-of-range channels are still handshaken but otherwise ignored.
  assign w_do      = i_valid & r_ready & w_ch_ok & ~rst;
  assign w_bypass  = (delay == '0);
  // Natural FW-bit wrap gives the modulo-DEPTH ring index.
  assign w_rd_idx  = r_wr_ptr - delay;
  assign w_base    = AW'(i_channel) * AW'(DEPTH);
  assign w_raddr   = w_base + AW'(w_rd_idx);
  assign w_waddr   = w_clear ? r_clr_addr : (w_base + AW'(r_wr_ptr));
  assign w_wdata   = w_clear ? '0 : i_sample;
  assign w_we      = w_clear | w_do;
  // With delay 0 the read would hit the address being written; the
  // registered bypass supplies the sample instead.
  assign w_re      = w_do & ~w_bypass;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    if (w_re) r_rdata <= r_mem[w_raddr];
  end

  always_ff @(posedge clk) begin
    if (rst)                    r_wr_ptr <= '0;
    else if (w_do && w_ch_last) r_wr_ptr <= r_wr_ptr + 1'b1;
  end

  // The bypass register doubles as the zero source after reset, since the
  // RAM read register itself has no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovalid  <= 1'b0;
      r_och     <= '0;
      r_sel_byp <= 1'b1;
      r_byp     <= '0;
    end else begin
      r_ovalid <= w_do;
      if (w_do) begin
        r_och     <= i_channel;
        r_sel_byp <= w_bypass;
        r_byp     <= i_sample;
      end
    end
  end

  assign i_ready   = r_ready;
  assign o_valid   = r_ovalid;
  assign o_channel = r_och;
  assign o_sample  = r_sel_byp ? r_byp : r_rdata;

endmodule
